keccak_rho_pi_chi: RTL and testbench

Registered Keccak-f[1600] partial-round stage. It applies the Rho, Pi and Chi step mappings, in that order, to a 1600-bit state in one clock cycle.
It sits in the Keccak round datapath between the Theta stage and the Iota stage. The Iota stage adds the round constant to lane (0,0).
It has no storage beyond one pipeline register with a valid bit.

---
 rtl/keccak_pkg.sv | 34 +++
 rtl/keccak_rho_pi_chi_if.sv | 25 ++
 rtl/keccak_chi_row.sv | 17 +
 rtl/keccak_rho_pi_chi.sv | 89 ++++++++
 tb/tb_keccak_rho_pi_chi.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants: lane geometry, rho offsets and
// helpers for locating and rotating lanes inside the flat state vector.
package keccak_pkg;

  localparam int LANE_W   = 64;
  localparam int LANE_CNT = 25;
  localparam int STATE_W  = LANE_W * LANE_CNT;

  typedef logic [LANE_W-1:0] lane_t;

  // One row of five lanes, element [x] is lane x of the row.
  typedef logic [4:0][LANE_W-1:0] row_t;

  // Rho rotation amounts, indexed [x][y].
  localparam int unsigned RHO_OFFSET [5][5] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };

  // First bit of lane (x,y) in the [0:1599] state vector; bit z of that
  // lane sits at lane_base(x,y) + z.
  function automatic int lane_base(input int x, input int y);
    return LANE_W * (5 * y + x);
  endfunction

  // Rotate toward higher z: result[z] = v[(z - r) mod 64].
  function automatic lane_t rotl(input lane_t v, input int unsigned r);
    return (v << r) | (v >> ((LANE_W - r) % LANE_W));
  endfunction

endpackage

// File: rtl/keccak_rho_pi_chi_if.sv
// State-transfer bus for the rho/pi/chi stage: a valid-qualified input
// state from theta and a valid-qualified registered result for iota.
interface keccak_rho_pi_chi_if;
  import keccak_pkg::*;

  logic               in_valid;
  logic [0:STATE_W-1] S_in;
  logic               out_valid;
  logic [0:STATE_W-1] S_out;

  modport master (
    output in_valid,
    output S_in,
    input  out_valid,
    input  S_out
  );

  modport slave (
    input  in_valid,
    input  S_in,
    output out_valid,
    output S_out
  );

endinterface

// File: rtl/keccak_chi_row.sv
// Chi step for a single row of five lanes: each lane is XORed with
// (NOT next lane AND the lane after that), indices wrapping mod 5.
module keccak_chi_row
  import keccak_pkg::*;
(
  input  row_t row_in,
  output row_t row_out
);

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_lane
      assign row_out[gi] = row_in[gi] ^ (~row_in[(gi + 1) % 5] & row_in[(gi + 2) % 5]);
    end
  endgenerate

endmodule

// File: rtl/keccak_rho_pi_chi.sv
// Keccak-f[1600] rho -> pi -> chi in one combinational pass, followed by a
// single output register with a valid bit. Rho and pi are pure wiring; chi
// is done by five row instances. Throughput one state per cycle, latency 1.
module keccak_rho_pi_chi
  import keccak_pkg::*;
(
  input logic                clk,
  input logic                rst,
  keccak_rho_pi_chi_if.slave bus
);

  // Rows are indexed [y], lanes inside a row [x].
  row_t a_row [5];
  row_t b_row [5];
  row_t c_row [5];
  row_t d_row [5];

  logic [0:STATE_W-1] d_flat;
  logic [0:STATE_W-1] s_out_reg;
  logic               out_valid_reg;

  // Unpack the flat input vector into lanes (bit z of a lane is lane[z]).
  always_comb begin
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        for (int z = 0; z < LANE_W; z++) begin
          a_row[y][x][z] = bus.S_in[lane_base(x, y) + z];
        end
      end
    end
  end

  // Rho: rotate every lane toward higher z by its fixed offset.
  always_comb begin
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        b_row[y][x] = rotl(a_row[y][x], RHO_OFFSET[x][y]);
      end
    end
  end

  // Pi: lane (x,y) takes the rotated lane from position ((x+3y) mod 5, x).
  always_comb begin
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        c_row[y][x] = b_row[x][(x + 3 * y) % 5];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_chi
      keccak_chi_row u_chi_row (
        .row_in  (c_row[gi]),
        .row_out (d_row[gi])
      );
    end
  endgenerate

  // Repack the chi result into the flat state layout.
  always_comb begin
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        for (int z = 0; z < LANE_W; z++) begin
          d_flat[lane_base(x, y) + z] = d_row[y][x][z];
        end
      end
    end
  end

  // Output register: capture on valid input, hold data otherwise; reset
  // discards any in-flight result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      s_out_reg     <= '0;
    end else if (bus.in_valid) begin
      out_valid_reg <= 1'b1;
      s_out_reg     <= d_flat;
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.S_out     = s_out_reg;

endmodule

// File: tb/tb_keccak_rho_pi_chi.sv
// Self-checking bench for keccak_rho_pi_chi: reset behaviour, a table of
// known vectors, a back-to-back throughput burst, and randomized states
// with asynchronous reset pulses checked against a bit-level reference.
module tb_keccak_rho_pi_chi;

  localparam int SW = 1600;

  typedef logic [0:SW-1] state_t;

  typedef struct {
    string  name;
    state_t s_in;
    state_t s_exp;
  } vec_t;

  // Rho offsets indexed [y][x], as a row per y.
  localparam int RHO_TBL [5][5] = '{
    '{ 0,  1, 62, 28, 27},
    '{36, 44,  6, 55, 20},
    '{ 3, 10, 43, 25, 39},
    '{41, 45, 15, 21,  8},
    '{18,  2, 61, 56, 14}
  };

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  keccak_rho_pi_chi_if bus ();

  keccak_rho_pi_chi dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: apply the step mappings bit by bit on a 5x5x64 array.
  function automatic state_t ref_model(input state_t s);
    bit     a [5][5][64];
    bit     b [5][5][64];
    bit     c [5][5][64];
    state_t d;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 64; z++)
          a[x][y][z] = s[64 * (5 * y + x) + z];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 64; z++)
          b[x][y][z] = a[x][y][(z - RHO_TBL[y][x] + 64) % 64];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 64; z++)
          c[x][y][z] = b[(x + 3 * y) % 5][x][z];
    d = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 64; z++)
          d[64 * (5 * y + x) + z] = c[x][y][z] ^ (~c[(x + 1) % 5][y][z] & c[(x + 2) % 5][y][z]);
    return d;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int k = 0; k < SW / 32; k++) s[k * 32 +: 32] = $urandom();
    return s;
  endfunction

  function automatic logic [63:0] lane_of(input state_t s, input int l);
    logic [63:0] v;
    for (int z = 0; z < 64; z++) v[z] = s[64 * l + z];
    return v;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_state(input string name, input state_t got, input state_t exp);
    int first;
    checks++;
    if (got !== exp) begin
      errors++;
      first = -1;
      for (int l = 24; l >= 0; l--)
        if (lane_of(got, l) !== lane_of(exp, l)) first = l;
      $display("FAIL %s: lane %0d got %h expected %h", name, first,
               lane_of(got, first), lane_of(exp, first));
    end
  endtask

  vec_t   vecs [4];
  state_t burst [3];
  state_t s_tmp;
  state_t exp_s;
  logic   exp_v;

  initial begin
    checks = 0;
    errors = 0;

    // Known vectors with hand-derived results.
    vecs[0].name = "zero";  vecs[0].s_in = '0;  vecs[0].s_exp = '0;
    vecs[1].name = "ones";  vecs[1].s_in = '1;  vecs[1].s_exp = '1;
    s_tmp = '0; s_tmp[0] = 1'b1;
    vecs[2].name = "bit0";  vecs[2].s_in = s_tmp;
    s_tmp = '0; s_tmp[0] = 1'b1; s_tmp[192] = 1'b1;
    vecs[2].s_exp = s_tmp;
    s_tmp = '0; s_tmp[64] = 1'b1;
    vecs[3].name = "bit64"; vecs[3].s_in = s_tmp;
    s_tmp = '0; s_tmp[641] = 1'b1; s_tmp[833] = 1'b1;
    vecs[3].s_exp = s_tmp;

    // Reset with valid input present: nothing may appear.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.S_in = rand_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_valid", bus.out_valid, 1'b0);
    check_state("reset_data", bus.S_out, '0);

    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_bit("idle_after_reset", bus.out_valid, 1'b0);

    // Table-driven vectors, one per cycle with a check after each edge.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.S_in = vecs[i].s_in;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_bit({vecs[i].name, "_valid"}, bus.out_valid, 1'b1);
      check_state(vecs[i].name, bus.S_out, vecs[i].s_exp);
      $display("vector %s checked", vecs[i].name);
    end

    // Throughput: three states back to back, then idle with data held.
    for (int i = 0; i < 3; i++) burst[i] = rand_state();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.S_in = burst[i];
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_bit("burst_valid", bus.out_valid, 1'b1);
      check_state("burst_data", bus.S_out, ref_model(burst[i]));
      $display("burst state %0d checked", i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.S_in = rand_state();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_bit("burst_idle_valid", bus.out_valid, 1'b0);
      check_state("burst_hold", bus.S_out, ref_model(burst[2]));
    end

    // Randomized run with asynchronous reset pulses between edges.
    exp_v = 1'b0;
    exp_s = ref_model(burst[2]);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus.S_in = rand_state();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        #2 rst = 1'b1;
        #1;
        check_bit("async_rst_valid", bus.out_valid, 1'b0);
        check_state("async_rst_data", bus.S_out, '0);
        #1 rst = 1'b0;
        exp_s = '0;
        $display("rand %0d: async reset pulse", i);
      end
      @(posedge clk); #1;
      if (bus.in_valid) begin
        exp_v = 1'b1;
        exp_s = ref_model(bus.S_in);
      end else begin
        exp_v = 1'b0;
      end
      check_bit("rand_valid", bus.out_valid, exp_v);
      check_state("rand_data", bus.S_out, exp_s);
      $display("rand %0d: in_valid=%0b checked", i, bus.in_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
